mem_arbiter: RTL and testbench

Two-port sequencer that shares the single byte-lane data memory between the XM23 instruction-fetch path and the load/store (data) path. Each port issues a request with address, direction, byte/word size and write data; the block serialises the accesses, drives the memory's lower/upper byte-lane address, data and control pins, captures read data and returns a one-cycle completion pulse. It sits between the control unit's MAR/MDR sequencing and the `memory` instance.

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto the shared byte-lane memory.
// MEM_ARB_RR_EN selects round-robin tie-break; undefined gives data-over-fetch priority.
module mem_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   input  logic        dt_req,
   input  logic [15:0] dt_addr,
   input  logic        dt_wr,
   input  logic        dt_byte,
   input  logic [15:0] dt_wdata,
   output logic        if_done,
   output logic        dt_done,
   output logic [15:0] rdata,
   output logic        err,
   output logic        busy,
   output logic        owner,
   output logic [15:0] mem_lb_addr,
   output logic [15:0] mem_ub_addr,
   output logic [7:0]  mem_wd_lb,
   output logic [7:0]  mem_wd_ub,
   output logic        mem_byte,
   output logic        mem_wr,
   input  logic [7:0]  mem_rd_lb,
   input  logic [7:0]  mem_rd_ub
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} st_t;
   st_t         st_q, st_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
   logic        wr_q, wr_d, byte_q, byte_d, own_q, own_d, err_q, err_d;
   logic        pick_dt, mis;
`ifdef MEM_ARB_RR_EN
   assign pick_dt = dt_req & (~if_req | ~own_q);
`else
   assign pick_dt = dt_req;
`endif
   assign mis = ~(pick_dt & dt_byte) & (pick_dt ? dt_addr[0] : if_addr[0]);
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      wr_d    = wr_q;
      byte_d  = byte_q;
      own_d   = own_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (st_q)
         IDLE: if (if_req | dt_req) begin
            addr_d  = pick_dt ? dt_addr : if_addr;
            wd_d    = pick_dt ? dt_wdata : 16'h0000;
            wr_d    = pick_dt & dt_wr;
            byte_d  = pick_dt & dt_byte;
            own_d   = pick_dt;
            err_d   = mis;
            rdata_d = mis ? 16'h0000 : rdata_q;
            st_d    = mis ? DONE : ISSUE;
         end
         ISSUE: begin
            cnt_d = 3'(RD_LAT);
            st_d  = WAIT;
         end
         WAIT: if (cnt_q == 3'd1) begin
            rdata_d = wr_q ? rdata_q : byte_q ? {8'h00, mem_rd_lb} : {mem_rd_ub, mem_rd_lb};
            st_d    = DONE;
         end else cnt_d = cnt_q - 3'd1;
         default: st_d = IDLE;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         st_q    <= IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= 16'h0000;
         wd_q    <= 16'h0000;
         wr_q    <= 1'b0;
         byte_q  <= 1'b0;
         own_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         wr_q    <= wr_d;
         byte_q  <= byte_d;
         own_q   <= own_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end
   // reset gates the strobe so a write caught in ISSUE never reaches memory
   assign mem_wr      = (st_q == ISSUE) & wr_q & Reset_n;
   assign mem_byte    = byte_q;
   assign mem_lb_addr = addr_q;
   assign mem_ub_addr = addr_q + 16'd1;
   assign mem_wd_lb   = wd_q[7:0];
   assign mem_wd_ub   = wd_q[15:8];
   assign if_done     = (st_q == DONE) & ~own_q;
   assign dt_done     = (st_q == DONE) & own_q;
   assign rdata       = rdata_q;
   assign err         = err_q;
   assign busy        = st_q != IDLE;
   assign owner       = own_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a byte-lane memory model.
module tb_mem_arbiter;
   localparam int L = 4;
   logic        Clock = 0, Reset_n = 0;
   logic        if_req = 0, dt_req = 0, dt_wr = 0, dt_byte = 0;
   logic [15:0] if_addr = 0, dt_addr = 0, dt_wdata = 0;
   logic        if_done, dt_done, err, busy, owner, mem_byte, mem_wr;
   logic [15:0] rdata, mem_lb_addr, mem_ub_addr;
   logic [7:0]  mem_wd_lb, mem_wd_ub, mem_rd_lb, mem_rd_ub;
   logic [7:0]  mem [0:65535];
   int          checks = 0, failures = 0, wr_cnt = 0, n, w0, dsum;

   mem_arbiter #(.RD_LAT(L)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .if_req(if_req), .if_addr(if_addr),
      .dt_req(dt_req), .dt_addr(dt_addr), .dt_wr(dt_wr), .dt_byte(dt_byte),
      .dt_wdata(dt_wdata), .if_done(if_done), .dt_done(dt_done), .rdata(rdata),
      .err(err), .busy(busy), .owner(owner), .mem_lb_addr(mem_lb_addr),
      .mem_ub_addr(mem_ub_addr), .mem_wd_lb(mem_wd_lb), .mem_wd_ub(mem_wd_ub),
      .mem_byte(mem_byte), .mem_wr(mem_wr), .mem_rd_lb(mem_rd_lb), .mem_rd_ub(mem_rd_ub)
   );

   always #5 Clock = ~Clock;
   assign mem_rd_lb = mem[mem_lb_addr];
   assign mem_rd_ub = mem[mem_ub_addr];
   always @(posedge Clock) if (mem_wr) begin
      wr_cnt <= wr_cnt + 1;
      mem[mem_lb_addr] <= mem_wd_lb;
      if (!mem_byte) mem[mem_ub_addr] <= mem_wd_ub;
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic wait_done(output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (!(if_done | dt_done) && k < 30);
   endtask

   task automatic access(input logic d, input logic wr, input logic by, input logic [15:0] a,
                         input logic [15:0] wd, output int k);
      if (d) begin
         dt_req = 1; dt_addr = a; dt_wr = wr; dt_byte = by; dt_wdata = wd;
      end else begin
         if_req = 1; if_addr = a;
      end
      wait_done(k);
      if_req = 0;
      dt_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
      mem[16'h0022] = 8'h77;
      mem[16'h0030] = 8'hCD; mem[16'h0031] = 8'hAB;
      mem[16'h0050] = 8'h66; mem[16'h0051] = 8'h55;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_byte", mem_byte, 0);
      chk("rst_lb", mem_lb_addr, 0);
      chk("rst_wd", {mem_wd_ub, mem_wd_lb}, 0);
      chk("rst_done", {if_done, dt_done}, 0);
      Reset_n = 1;
      tick();
      // word fetch
      w0 = wr_cnt;
      access(0, 0, 0, 16'h0010, 0, n);
      chk("rd_lat", n, L + 2);
      chk("rd_done", {if_done, dt_done}, 2'b10);
      chk("rd_data", rdata, 16'h1234);
      chk("rd_err", err, 0);
      chk("rd_noWr", wr_cnt - w0, 0);
      tick();
      chk("rd_idle", busy, 0);
      // byte write then byte read
      w0 = wr_cnt;
      access(1, 1, 1, 16'h0021, 16'hBEEF, n);
      chk("bw_lat", n, L + 2);
      chk("bw_done", {if_done, dt_done}, 2'b01);
      chk("bw_owner", owner, 1);
      chk("bw_keep", rdata, 16'h1234);
      chk("bw_wrcnt", wr_cnt - w0, 1);
      chk("bw_lb", mem[16'h0021], 8'hEF);
      chk("bw_ub", mem[16'h0022], 8'h77);
      tick();
      access(1, 0, 1, 16'h0021, 0, n);
      chk("br_data", rdata, 16'h00EF);
      tick();
      // misaligned word read
      w0 = wr_cnt;
      access(1, 0, 0, 16'h0013, 0, n);
      chk("mis_lat", n, 1);
      chk("mis_done", dt_done, 1);
      chk("mis_err", err, 1);
      chk("mis_data", rdata, 0);
      chk("mis_noWr", wr_cnt - w0, 0);
      tick();
      // reset mid-WAIT abandons the read
      if_req = 1; if_addr = 16'h0010;
      tick(); tick(); tick();
      chk("rw_busy", busy, 1);
      Reset_n = 0; if_req = 0;
      tick();
      Reset_n = 1;
      chk("rw_rbusy", busy, 0);
      dsum = 0;
      for (int i = 0; i < L + 3; i++) begin
         dsum += int'(if_done) + int'(dt_done);
         tick();
      end
      chk("rw_nodone", dsum, 0);
      access(0, 0, 0, 16'h0010, 0, n);
      chk("rw_lat", n, L + 2);
      chk("rw_data", rdata, 16'h1234);
      tick();
      // reset while a write sits in ISSUE
      w0 = wr_cnt;
      dt_req = 1; dt_addr = 16'h0050; dt_wr = 1; dt_byte = 0; dt_wdata = 16'h9999;
      tick();
      Reset_n = 0; dt_req = 0;
      tick();
      Reset_n = 1;
      chk("ri_noWr", wr_cnt - w0, 0);
      chk("ri_mem", {mem[16'h0051], mem[16'h0050]}, 16'h5566);
      chk("ri_owner", owner, 0);
      // tie, both requests held across two accesses
      if_req = 1; if_addr = 16'h0010;
      dt_req = 1; dt_addr = 16'h0030; dt_wr = 0; dt_byte = 0;
      wait_done(n);
      chk("tie1_lat", n, L + 2);
      chk("tie1_done", {if_done, dt_done}, 2'b01);
      chk("tie1_data", rdata, 16'hABCD);
      wait_done(n);
      chk("tie2_lat", n, L + 3);
`ifdef MEM_ARB_RR_EN
      chk("tie2_done", {if_done, dt_done}, 2'b10);
      chk("tie2_data", rdata, 16'h1234);
`else
      chk("tie2_done", {if_done, dt_done}, 2'b01);
      chk("tie2_data", rdata, 16'hABCD);
`endif
      if_req = 0; dt_req = 0;
      tick();
      // address wrap
      w0 = wr_cnt;
      access(1, 1, 0, 16'hFFFE, 16'hA55A, n);
      chk("wr_wrcnt", wr_cnt - w0, 1);
      chk("wr_lbA", mem_lb_addr, 16'hFFFE);
      chk("wr_ubA", mem_ub_addr, 16'hFFFF);
      chk("wr_mem", {mem[16'hFFFF], mem[16'hFFFE]}, 16'hA55A);
      tick();
      access(1, 0, 0, 16'hFFFE, 0, n);
      chk("wrap_rd", rdata, 16'hA55A);
      chk("wrap_err", err, 0);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
